sargantana_icache_replace_unit: RTL
===================================

# sargantana_icache_replace_unit

Victim-way selection stage for the 4-way instruction cache refill path. On a refill request it samples the valid bits of the indexed set and picks a victim:
- the lowest-numbered invalid way, if any way is invalid;
- otherwise a pseudo-random way from an 8-bit LFSR.

It then holds that victim stable, as a one-hot write enable and an index, until the refill completes or is flushed.

## Interface
- ICACHE_N_WAY, 4, number of ways; only 4 is supported because the way decoder is fixed to 4.
- LFSR_SEED, 8'h01, LFSR reset value; must be non-zero.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; one clock; reset is asynchronous and active-low.
- valid_ways_i  in  ICACHE_N_WAY  valid bits of the set being refilled.
- refill_req_i  in  1  level request for a victim; the requester holds it until way_valid_o rises.
- refill_done_i  in  1  one-cycle pulse marking the end of the refill write.
- flush_i  in  1  abort or invalidate; forces IDLE.
- way_o  out  ICACHE_N_WAY  one-hot victim way, used as the data/tag write enable.
- way_idx_o  out  $clog2(ICACHE_N_WAY)  binary victim index.
- way_valid_o  out  1  victim is latched and stable.
- random_o  out  1  victim came from the LFSR because all ways were valid.

## Operation
- FSM has two states: IDLE and HOLD.
- IDLE to HOLD:
  - Taken when refill_req_i=1 and flush_i=0.
  - The victim is computed combinationally from valid_ways_i in this cycle and registered.
- Victim rule:
  - If valid_ways_i != all-ones: the lowest index i with valid_ways_i[i]=0, and random_o=0.
  - Otherwise: lfsr[1:0], using the pre-advance value, and random_o=1.
- LFSR:
  - Fibonacci, 8-bit; feedback fb = l[7]^l[5]^l[4]^l[3]; next value = {l[6:0], fb}.
  - Advances once per accepted request (IDLE to HOLD), whether or not the victim was random. It never advances otherwise.
  - flush_i does not touch it.
- HOLD:
  - way_o, way_idx_o and random_o are frozen and way_valid_o=1.
  - refill_req_i and valid_ways_i are ignored.
- HOLD to IDLE: taken on refill_done_i=1 or flush_i=1. On that transition way_valid_o and way_o clear; way_idx_o and random_o clear as well.
- refill_done_i in IDLE is ignored.
- flush_i in IDLE blocks acceptance in that cycle, even if refill_req_i=1.
- If refill_done_i and flush_i are both high in HOLD, the result is the same as either alone: go to IDLE.
- No back-to-back acceptance: at least one IDLE cycle separates consecutive victims.

## Timing
- Reset values: state IDLE, way_o=0, way_idx_o=0, way_valid_o=0, random_o=0, lfsr=LFSR_SEED.
- Latency: a request accepted in cycle N gives way_valid_o=1 with the victim from cycle N+1.
- Release: refill_done_i in cycle M gives way_valid_o=0 in cycle M+1. The earliest next victim is valid in cycle M+2.
- All outputs are registered; there is no combinational path from any input to any output.
- Asynchronous reset mid-HOLD: outputs drop immediately to their reset values and the LFSR reloads the seed.

## Structure
- A shared icache package holds:
  - ICACHE_N_WAY;
  - the way-index width, localparam `$clog2(ICACHE_N_WAY)`;
  - an LFSR width constant (8);
  - the FSM state enum (IDLE, HOLD).
- Sub-module: sargantana_icache_tzc computes the invalid-way index.
  - It takes ~valid_ways_i.
  - Its empty_o output means all ways are valid and selects the LFSR path.
- The one-hot way_o is decoded from the selected index inside this block.

## Test plan
- Reset, then valid_ways_i=4'b1011 and refill_req_i=1 -> next cycle way_valid_o=1, way_o=4'b0100, way_idx_o=2, random_o=0. The LFSR reads 8'h02 afterwards.
- After the first case, drive valid_ways_i=4'b0000 and refill_done_i=1 -> way_valid_o=0 the next cycle. A following request gives way_o=4'b0001 and idx 0.
- From reset, valid_ways_i=4'b1111 with three request/done sequences -> victims idx 1, 2, 0 (LFSR 01→02→04→08), random_o=1 each time.
- In HOLD, change valid_ways_i and keep refill_req_i=1 for 5 cycles -> way_o is unchanged and the LFSR is unchanged.
- flush_i in HOLD -> IDLE next cycle with way_valid_o=0. flush_i together with refill_req_i in IDLE -> no acceptance and the LFSR is unchanged.
- Assert rstn_i low asynchronously mid-HOLD -> all outputs drop to 0 before the next edge. After release, a full-set request gives victim idx 1 again.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared instruction-cache constants, FSM state type and LFSR step helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sargantana_icache_pkg;

   localparam int ICACHE_N_WAY = 4;
   localparam int WAY_IDX_W    = $clog2(ICACHE_N_WAY);
   localparam int LFSR_W       = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } repl_state_t;

   // One Fibonacci step: taps 7,5,4,3 feed back into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

endpackage

// File: rtl/sargantana_icache_tzc.sv
// Trailing-zero counter: index of the lowest set bit of bits_i, empty_o when none set.
// Latency: purely combinational.
// Backpressure: none.
module sargantana_icache_tzc
   import sargantana_icache_pkg::*;
(
   input  logic [ICACHE_N_WAY-1:0] bits_i,
   output logic [WAY_IDX_W-1:0]    idx_o,
   output logic                    empty_o
);

   // Scan from the top so the lowest set bit is the last one to win.
   always_comb begin
      idx_o = '0;
      for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
         if (bits_i[i]) begin
            idx_o = WAY_IDX_W'(i);
         end
      end
   end

   assign empty_o = ~|bits_i;

endmodule

// File: rtl/sargantana_icache_replace_unit.sv
// Victim-way selection for icache refill: first invalid way, else LFSR-chosen way.
// Latency: request accepted in cycle N gives a registered victim in cycle N+1.
// Backpressure: victim held until refill_done_i/flush_i; requester holds refill_req_i meanwhile.
module sargantana_icache_replace_unit
   import sargantana_icache_pkg::*;
#(
   parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01
)(
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic [ICACHE_N_WAY-1:0] valid_ways_i,
   input  logic                    refill_req_i,
   input  logic                    refill_done_i,
   input  logic                    flush_i,
   output logic [ICACHE_N_WAY-1:0] way_o,
   output logic [WAY_IDX_W-1:0]    way_idx_o,
   output logic                    way_valid_o,
   output logic                    random_o
);

   repl_state_t              state_q, state_d;
   logic [LFSR_W-1:0]        lfsr_q;
   logic [ICACHE_N_WAY-1:0]  way_q;
   logic [WAY_IDX_W-1:0]     idx_q;
   logic                     random_q;
   logic                     accept;
   logic                     release_hold;

   logic [WAY_IDX_W-1:0]     inv_idx;
   logic                     all_valid;
   logic [WAY_IDX_W-1:0]     sel_idx;

   // Lowest invalid way; all_valid steers selection to the LFSR.
   sargantana_icache_tzc u_tzc (
      .bits_i  (~valid_ways_i),
      .idx_o   (inv_idx),
      .empty_o (all_valid)
   );

   assign sel_idx = all_valid ? lfsr_q[WAY_IDX_W-1:0] : inv_idx;

   // Next-state logic: accept in IDLE unless flushed, release in HOLD on done or flush.
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      release_hold = 1'b0;
      case (state_q)
         IDLE: begin
            if (refill_req_i && !flush_i) begin
               accept  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (refill_done_i || flush_i) begin
               release_hold = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, victim and LFSR registers; LFSR steps only on acceptance.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         lfsr_q   <= LFSR_SEED;
         way_q    <= '0;
         idx_q    <= '0;
         random_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            lfsr_q   <= lfsr_step(lfsr_q);
            way_q    <= ICACHE_N_WAY'(1) << sel_idx;
            idx_q    <= sel_idx;
            random_q <= all_valid;
         end else if (release_hold) begin
            way_q    <= '0;
            idx_q    <= '0;
            random_q <= 1'b0;
         end
      end
   end

   assign way_o       = way_q;
   assign way_idx_o   = idx_q;
   assign random_o    = random_q;
   assign way_valid_o = (state_q == HOLD);

endmodule
